// File: rtl/dht11_pkg.sv
// dht11_pkg: state codes (equal to the debug state port values), default timing, checksum helper
package dht11_pkg;
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_HOST_LOW = 4'd1,
        S_DELAY    = 4'd2,
        S_R_LOW    = 4'd3,
        S_R_HIGH   = 4'd4,
        S_B_LOW    = 4'd5,
        S_B_HIGH   = 4'd6,
        S_END      = 4'd7
    } state_t;
    localparam int DEF_CLKS_PER_US  = 50;
    localparam int DEF_START_MIN_US = 17000;
    localparam int DEF_RESP_DELAY_US = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 26;
    localparam int DEF_BIT1_HIGH_US = 70;
    localparam int US_W = 16;
    function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction
endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: free-running prescaler, one-cycle tick every CLKS_PER_US sys_clk cycles
module dht11_us_tick #(
    parameter int CLKS_PER_US = 50
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);
    localparam int W = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLKS_PER_US - 1);
    always_ff @(posedge sys_clk)
        if (rst) cnt <= '0;
        else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator (start detect, presence reply, 40-bit frame).
// Define DHT11_FAULT_INJ_EN to add corrupt_chk, which flips checksum bit 0 at the snapshot.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLKS_PER_US   = DEF_CLKS_PER_US,
    parameter int START_MIN_US  = DEF_START_MIN_US,
    parameter int RESP_DELAY_US = DEF_RESP_DELAY_US,
    parameter int RESP_LOW_US   = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US  = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US    = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US  = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US  = DEF_BIT1_HIGH_US
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       dht11_in,
    output logic       dht11_oe,
    input  logic [7:0] humi_int,
    input  logic [7:0] humi_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done,
    output logic       err_start,
    output logic [3:0] state
`ifdef DHT11_FAULT_INJ_EN
    ,
    input  logic       corrupt_chk
`endif
);
    logic s1, s2, prev, fall, rise, tick, fin;
    logic [US_W-1:0] us_cnt, lim;
    logic [39:0] sh;
    logic [5:0] bit_cnt;
    logic [7:0] chk;
    state_t st;

    dht11_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (.sys_clk(sys_clk), .rst(rst), .tick(tick));

    // idle bus is high, so the synchronizer resets high to avoid a false start edge
    always_ff @(posedge sys_clk)
        if (rst) {s1, s2, prev} <= 3'b111;
        else {s1, s2, prev} <= {dht11_in, s1, s2};
    assign fall = prev & ~s2;
    assign rise = ~prev & s2;

`ifdef DHT11_FAULT_INJ_EN
    assign chk = checksum(humi_int, humi_dec, temp_int, temp_dec) ^ {7'd0, corrupt_chk};
`else
    assign chk = checksum(humi_int, humi_dec, temp_int, temp_dec);
`endif

    assign lim = st == S_DELAY  ? US_W'(RESP_DELAY_US - 1) :
                 st == S_R_LOW  ? US_W'(RESP_LOW_US - 1) :
                 st == S_R_HIGH ? US_W'(RESP_HIGH_US - 1) :
                 st == S_B_HIGH ? (sh[39] ? US_W'(BIT1_HIGH_US - 1) : US_W'(BIT0_HIGH_US - 1)) :
                 US_W'(BIT_LOW_US - 1);
    assign fin = tick && us_cnt == lim;
    assign state = st;

    always_ff @(posedge sys_clk)
        if (rst) begin
            st         <= S_IDLE;
            us_cnt     <= '0;
            sh         <= '0;
            bit_cnt    <= '0;
            dht11_oe   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_start  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_start  <= 1'b0;
            if (tick && !(st == S_HOST_LOW && us_cnt >= US_W'(START_MIN_US))) us_cnt <= us_cnt + US_W'(1);
            case (st)
                S_IDLE: if (fall) begin
                    st     <= S_HOST_LOW;
                    us_cnt <= '0;
                end
                S_HOST_LOW: if (rise) begin
                    us_cnt <= '0;
                    if (us_cnt >= US_W'(START_MIN_US)) begin
                        st   <= S_DELAY;
                        busy <= 1'b1;
                    end else begin
                        st        <= S_IDLE;
                        err_start <= 1'b1;
                    end
                end
                S_DELAY: if (fin) begin
                    st       <= S_R_LOW;
                    us_cnt   <= '0;
                    dht11_oe <= 1'b1;
                    sh       <= {humi_int, humi_dec, temp_int, temp_dec, chk};
                end
                S_R_LOW: if (fin) begin
                    st       <= S_R_HIGH;
                    us_cnt   <= '0;
                    dht11_oe <= 1'b0;
                end
                S_R_HIGH: if (fin) begin
                    st       <= S_B_LOW;
                    us_cnt   <= '0;
                    dht11_oe <= 1'b1;
                    bit_cnt  <= '0;
                end
                S_B_LOW: if (fin) begin
                    st       <= S_B_HIGH;
                    us_cnt   <= '0;
                    dht11_oe <= 1'b0;
                end
                S_B_HIGH: if (fin) begin
                    st       <= bit_cnt == 6'd39 ? S_END : S_B_LOW;
                    us_cnt   <= '0;
                    dht11_oe <= 1'b1;
                    sh       <= {sh[38:0], 1'b0};
                    bit_cnt  <= bit_cnt + 6'd1;
                end
                S_END: if (fin) begin
                    st         <= S_IDLE;
                    us_cnt     <= '0;
                    dht11_oe   <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end
                default: st <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: drives host start pulses, decodes the emulated sensor frame from dht11_oe
// and compares against a byte-level model; timing scaled down via CLKS_PER_US/START_MIN_US.
module tb_dht11_responder;
    localparam int C = 2;
    localparam int SMIN = 170;
    logic sys_clk = 1'b0, rst = 1'b1, host_low = 1'b0;
    logic [7:0] hi = 8'h00, hd = 8'h00, ti = 8'h00, td = 8'h00;
    logic dht11_in, dht11_oe, busy, frame_done, err_start;
    logic [3:0] state;
    int pass_n = 0, tot = 0, fd_cnt = 0, err_cnt = 0;
`ifdef DHT11_FAULT_INJ_EN
    logic corrupt_chk = 1'b0;
`endif

    assign dht11_in = !(dht11_oe || host_low);
    always #5 sys_clk = ~sys_clk;

    dht11_responder #(.CLKS_PER_US(C), .START_MIN_US(SMIN)) dut (
        .sys_clk(sys_clk), .rst(rst), .dht11_in(dht11_in), .dht11_oe(dht11_oe),
        .humi_int(hi), .humi_dec(hd), .temp_int(ti), .temp_dec(td),
        .busy(busy), .frame_done(frame_done), .err_start(err_start), .state(state)
`ifdef DHT11_FAULT_INJ_EN
        , .corrupt_chk(corrupt_chk)
`endif
    );

    always @(negedge sys_clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (err_start) err_cnt <= err_cnt + 1;
    end

    function automatic logic [39:0] model(input int a, input int b, input int c, input int d, input bit flip);
        int s;
        s = ((a + b + c + d) % 256) ^ (flip ? 1 : 0);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(s)};
    endfunction

    function automatic bit in_tol(input int n, input int us);
        return n >= (us - 1) * C && n <= us * C + 1;
    endfunction

    task automatic wait_oe(input logic lvl, output int n, output bit to);
        n = 0;
        to = 0;
        while (dht11_oe !== lvl) begin
            @(negedge sys_clk);
            n++;
            if (n > 200 * C) begin
                to = 1;
                return;
            end
        end
    endtask

    task automatic host_start(input int us);
        @(negedge sys_clk);
        host_low = 1'b1;
        repeat (us * C) @(negedge sys_clk);
        host_low = 1'b0;
    endtask

    // act: 1 = change temp_int to 0x20 at start of bit act_bit, 2 = pulse rst there and stop
    task automatic receive(input int act_bit, input int act, output logic [39:0] d,
                           output int dly, output int rl, output int rh, output bit tim_ok,
                           output bit all_ones_time, output bit to);
        int n;
        bit t, b;
        d = '0;
        tim_ok = 1;
        all_ones_time = 1;
        wait_oe(1'b1, dly, to);
        wait_oe(1'b0, rl, t); to |= t;
        wait_oe(1'b1, rh, t); to |= t;
        for (int i = 0; i < 40 && !to; i++) begin
            if (i == act_bit && act == 1) ti = 8'h20;
            if (i == act_bit && act == 2) begin
                rst = 1'b1;
                @(negedge sys_clk);
                rst = 1'b0;
                return;
            end
            wait_oe(1'b0, n, t); to |= t;
            if (!in_tol(n, 50)) tim_ok = 0;
            wait_oe(1'b1, n, t); to |= t;
            b = n > 48 * C;
            d = {d[38:0], b};
            if (!in_tol(n, b ? 70 : 26)) tim_ok = 0;
            if (i < 32 && !in_tol(n, 70)) all_ones_time = 0;
        end
        wait_oe(1'b0, n, t); to |= t;
        if (!in_tol(n, 50)) tim_ok = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        tot++; if (dht11_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", dht11_oe); else pass_n++;
        tot++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_n++;
        tot++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else pass_n++;
        tot++; if (err_start !== 1'b0) $display("FAIL reset_err_start got %b want 0", err_start); else pass_n++;
        tot++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else pass_n++;
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_basic();
        logic [39:0] d, exp;
        int dly, rl, rh, e0;
        bit ok, ones, to;
        {hi, hd, ti, td} = 32'h3C001900;
        exp = model(8'h3C, 8'h00, 8'h19, 8'h00, 0);
        e0 = fd_cnt;
        host_start(SMIN + 10);
        repeat (10) @(negedge sys_clk);
        tot++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else pass_n++;
        tot++; if (state !== 4'd2) $display("FAIL basic_state_delay got %0d want 2", state); else pass_n++;
        receive(-1, 0, d, dly, rl, rh, ok, ones, to);
        dly += 10;
        tot++; if (to) $display("FAIL basic_timeout got 1 want 0"); else pass_n++;
        tot++; if (dly < 29 * C || dly > 30 * C + 6) $display("FAIL basic_resp_delay got %0d cycles want ~%0d", dly, 30 * C); else pass_n++;
        tot++; if (!in_tol(rl, 80)) $display("FAIL basic_resp_low got %0d cycles want ~%0d", rl, 80 * C); else pass_n++;
        tot++; if (!in_tol(rh, 80)) $display("FAIL basic_resp_high got %0d cycles want ~%0d", rh, 80 * C); else pass_n++;
        tot++; if (d !== exp) $display("FAIL basic_frame got %h want %h", d, exp); else pass_n++;
        tot++; if (!ok) $display("FAIL basic_bit_timing got bad want ok"); else pass_n++;
        repeat (5) @(negedge sys_clk);
        tot++; if (fd_cnt - e0 != 1) $display("FAIL basic_frame_done got %0d want 1", fd_cnt - e0); else pass_n++;
        tot++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else pass_n++;
        tot++; if (state !== 4'd0) $display("FAIL basic_state_end got %0d want 0", state); else pass_n++;
    endtask

    task automatic test_short_start();
        int e0;
        bit seen;
        e0 = err_cnt;
        seen = 0;
        host_start(50);
        repeat (100 * C) begin
            @(negedge sys_clk);
            if (dht11_oe) seen = 1;
        end
        tot++; if (seen) $display("FAIL short_oe got 1 want 0"); else pass_n++;
        tot++; if (err_cnt - e0 != 1) $display("FAIL short_err_start got %0d want 1", err_cnt - e0); else pass_n++;
        tot++; if (state !== 4'd0) $display("FAIL short_state got %0d want 0", state); else pass_n++;
        tot++; if (busy !== 1'b0) $display("FAIL short_busy got %b want 0", busy); else pass_n++;
    endtask

    task automatic test_all_ones();
        logic [39:0] d, exp;
        int dly, rl, rh;
        bit ok, ones, to;
        {hi, hd, ti, td} = 32'hFFFFFFFF;
        exp = model(255, 255, 255, 255, 0);
        host_start(SMIN + 10);
        receive(-1, 0, d, dly, rl, rh, ok, ones, to);
        tot++; if (d !== exp || to) $display("FAIL ones_frame got %h want %h", d, exp); else pass_n++;
        tot++; if (d[7:0] !== 8'hFC) $display("FAIL ones_checksum got %h want fc", d[7:0]); else pass_n++;
        tot++; if (!ones || !ok) $display("FAIL ones_high_time got bad want 70us"); else pass_n++;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_snapshot();
        logic [39:0] d, exp;
        int dly, rl, rh;
        bit ok, ones, to;
        {hi, hd, ti, td} = 32'h3C001900;
        exp = model(8'h3C, 0, 8'h19, 0, 0);
        host_start(SMIN + 10);
        receive(10, 1, d, dly, rl, rh, ok, ones, to);
        tot++; if (d !== exp || to) $display("FAIL snap_old_frame got %h want %h", d, exp); else pass_n++;
        repeat (5) @(negedge sys_clk);
        exp = model(8'h3C, 0, 8'h20, 0, 0);
        host_start(SMIN + 10);
        receive(-1, 0, d, dly, rl, rh, ok, ones, to);
        tot++; if (d !== exp || to) $display("FAIL snap_new_frame got %h want %h", d, exp); else pass_n++;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_mid_reset();
        logic [39:0] d, exp;
        int dly, rl, rh, e0;
        bit ok, ones, to;
        {hi, hd, ti, td} = 32'h3C001900;
        exp = model(8'h3C, 0, 8'h19, 0, 0);
        e0 = fd_cnt;
        host_start(SMIN + 10);
        receive(20, 2, d, dly, rl, rh, ok, ones, to);
        tot++; if (dht11_oe !== 1'b0) $display("FAIL mid_reset_oe got %b want 0", dht11_oe); else pass_n++;
        tot++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy); else pass_n++;
        repeat (300) @(negedge sys_clk);
        tot++; if (fd_cnt != e0) $display("FAIL mid_reset_frame_done got %0d want 0", fd_cnt - e0); else pass_n++;
        tot++; if (state !== 4'd0) $display("FAIL mid_reset_state got %0d want 0", state); else pass_n++;
        host_start(SMIN + 10);
        receive(-1, 0, d, dly, rl, rh, ok, ones, to);
        tot++; if (d !== exp || to) $display("FAIL mid_reset_next_frame got %h want %h", d, exp); else pass_n++;
        repeat (5) @(negedge sys_clk);
        tot++; if (fd_cnt - e0 != 1) $display("FAIL mid_reset_next_done got %0d want 1", fd_cnt - e0); else pass_n++;
    endtask

    task automatic test_random();
        logic [39:0] d, exp;
        int dly, rl, rh, a, b, c, e;
        bit ok, ones, to;
        for (int k = 0; k < 2; k++) begin
            a = $urandom_range(255); b = $urandom_range(255);
            c = $urandom_range(255); e = $urandom_range(255);
            {hi, hd, ti, td} = {8'(a), 8'(b), 8'(c), 8'(e)};
            exp = model(a, b, c, e, 0);
            host_start(SMIN + 10);
            receive(-1, 0, d, dly, rl, rh, ok, ones, to);
            tot++; if (d !== exp || to) $display("FAIL random_frame%0d got %h want %h", k, d, exp); else pass_n++;
            tot++; if (!ok) $display("FAIL random_timing%0d got bad want ok", k); else pass_n++;
            repeat (5) @(negedge sys_clk);
        end
    endtask

`ifdef DHT11_FAULT_INJ_EN
    task automatic test_fault_inj();
        logic [39:0] d, exp;
        int dly, rl, rh;
        bit ok, ones, to;
        {hi, hd, ti, td} = 32'h3C001900;
        corrupt_chk = 1'b1;
        exp = model(8'h3C, 0, 8'h19, 0, 1);
        host_start(SMIN + 10);
        receive(-1, 0, d, dly, rl, rh, ok, ones, to);
        tot++; if (d !== exp || to) $display("FAIL fault_inj_frame got %h want %h", d, exp); else pass_n++;
        corrupt_chk = 1'b0;
        repeat (5) @(negedge sys_clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_short_start();
        test_all_ones();
        test_snapshot();
        test_mid_reset();
        test_random();
`ifdef DHT11_FAULT_INJ_EN
        test_fault_inj();
`endif
        $display("%0d/%0d checks passed", pass_n, tot);
        $finish;
    end
endmodule
